// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
// Writeback merge stage in front of the two-write-port register file.
// The ALU owns write port A and the LSU owns write port B. Multi-cycle
// results (div/FPU) wait in a small FIFO and drain into whichever port
// is idle, preferring port A. A per-register busy scoreboard tracks
// outstanding multi-cycle destinations and flags read hazards.

module riscv_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,

    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,

    input  logic                  mc_valid_i,
    output logic                  mc_ready_o,
    input  logic [ADDR_WIDTH-1:0] mc_addr_i,
    input  logic [DATA_WIDTH-1:0] mc_data_i,

    input  logic                  iss_valid_i,
    input  logic [ADDR_WIDTH-1:0] iss_addr_i,

    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  haz_a_o,
    output logic                  haz_b_o,
    output logic                  haz_c_o,

    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,

    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,

    output logic                  collision_o
);

    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    // Multi-cycle result buffer
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    logic                  ready_q;

    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;

    // Port arbitration
    logic                  collision;
    logic                  drain_a;
    logic                  drain_b;

    // Scoreboard
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    // Ready is a registered copy of "not full"; it is forced low while in reset
    // so no producer hands off a result that the reset would then discard.
    assign mc_ready_o = ready_q & ~rst;

    assign fifo_empty = (count == '0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    assign push = mc_valid_i & mc_ready_o;

    // A same-address ALU/LSU pair lets the load win; address zero never collides
    // because neither write would reach the register file anyway.
    assign collision = alu_valid_i & lsu_valid_i &
                       (alu_addr_i == lsu_addr_i) & (alu_addr_i != ZERO_ADDR);

    // Only one drain per cycle, and port A gets first claim on the head.
    assign drain_a = ~alu_valid_i & ~fifo_empty;
    assign drain_b = ~lsu_valid_i & ~fifo_empty & ~drain_a;
    assign pop     = (drain_a | drain_b) & ~rst;

    assign collision_o = collision & ~rst;

    // Write port A: ALU result if present, otherwise the FIFO head.
    always_comb begin
        we_a_o    = 1'b0;
        waddr_a_o = alu_addr_i;
        wdata_a_o = alu_data_i;
        if (alu_valid_i) begin
            we_a_o = ~rst & ~collision & (alu_addr_i != ZERO_ADDR);
        end else if (drain_a) begin
            waddr_a_o = head_addr;
            wdata_a_o = head_data;
            we_a_o    = ~rst & (head_addr != ZERO_ADDR);
        end
    end

    // Write port B: LSU result if present, otherwise the FIFO head when port A left it.
    always_comb begin
        we_b_o    = 1'b0;
        waddr_b_o = lsu_addr_i;
        wdata_b_o = lsu_data_i;
        if (lsu_valid_i) begin
            we_b_o = ~rst & (lsu_addr_i != ZERO_ADDR);
        end else if (drain_b) begin
            waddr_b_o = head_addr;
            wdata_b_o = head_data;
            we_b_o    = ~rst & (head_addr != ZERO_ADDR);
        end
    end

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_WIDTH'(1);
            2'b01:   count_next = count - CNT_WIDTH'(1);
            default: count_next = count;
        endcase
    end

    // Payload storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mc_addr_i;
            fifo_data[wr_ptr] <= mc_data_i;
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != FULL_COUNT);
        end
    end

    // Drains clear their destination, then issues set theirs so a same-cycle
    // reissue of the same register keeps it busy; register zero stays clear.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head_addr] = 1'b0;
        end
        if (iss_valid_i && (iss_addr_i != ZERO_ADDR)) begin
            busy_next[iss_addr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard flags read the registered busy bits; register zero never stalls.
    always_comb begin
        haz_a_o = ~rst & busy[raddr_a_i] & (raddr_a_i != ZERO_ADDR);
        haz_b_o = ~rst & busy[raddr_b_i] & (raddr_b_i != ZERO_ADDR);
        haz_c_o = ~rst & busy[raddr_c_i] & (raddr_c_i != ZERO_ADDR);
    end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter
// Directed scenarios for the writeback arbiter, each task driving its own
// vectors and checking hand-computed expectations.

module tb_riscv_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic [5:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic [5:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        mc_valid_i;
    logic        mc_ready_o;
    logic [5:0]  mc_addr_i;
    logic [31:0] mc_data_i;
    logic        iss_valid_i;
    logic [5:0]  iss_addr_i;
    logic [5:0]  raddr_a_i;
    logic [5:0]  raddr_b_i;
    logic [5:0]  raddr_c_i;
    logic        haz_a_o;
    logic        haz_b_o;
    logic        haz_c_o;
    logic        we_a_o;
    logic [5:0]  waddr_a_o;
    logic [31:0] wdata_a_o;
    logic        we_b_o;
    logic [5:0]  waddr_b_o;
    logic [31:0] wdata_b_o;
    logic        collision_o;

    int num_checks;
    int num_fails;

    riscv_wb_arbiter #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_addr_i  (alu_addr_i),
        .alu_data_i  (alu_data_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_data_i  (lsu_data_i),
        .mc_valid_i  (mc_valid_i),
        .mc_ready_o  (mc_ready_o),
        .mc_addr_i   (mc_addr_i),
        .mc_data_i   (mc_data_i),
        .iss_valid_i (iss_valid_i),
        .iss_addr_i  (iss_addr_i),
        .raddr_a_i   (raddr_a_i),
        .raddr_b_i   (raddr_b_i),
        .raddr_c_i   (raddr_c_i),
        .haz_a_o     (haz_a_o),
        .haz_b_o     (haz_b_o),
        .haz_c_o     (haz_c_o),
        .we_a_o      (we_a_o),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_b_o      (we_b_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .collision_o (collision_o)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
        mc_valid_i  = 1'b0; mc_addr_i  = '0; mc_data_i  = '0;
        iss_valid_i = 1'b0; iss_addr_i = '0;
        raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        alu_valid_i = 1'b1; alu_addr_i = 6'd3; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd3; lsu_data_i = 32'h2;
        mc_valid_i  = 1'b1; mc_addr_i  = 6'd4; mc_data_i  = 32'h4;
        iss_valid_i = 1'b1; iss_addr_i = 6'd5; raddr_a_i = 6'd5;
        @(negedge clk);
        num_checks++; if (mc_ready_o !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_ready: got %b expected 0", mc_ready_o); end
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_we_a: got %b expected 0", we_a_o); end
        num_checks++; if (we_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_we_b: got %b expected 0", we_b_o); end
        num_checks++; if (collision_o !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_collision: got %b expected 0", collision_o); end
        tick();
        rst = 1'b0;
        set_idle();
        raddr_a_i = 6'd5;
        @(negedge clk);
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL post_rst_ready: got %b expected 1", mc_ready_o); end
        num_checks++; if (haz_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL post_rst_haz_a: got %b expected 0", haz_a_o); end
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL post_rst_fifo_empty: got we_a %b expected 0", we_a_o); end
        tick();
    endtask

    task automatic test_fifo_bypass();
        set_idle();
        mc_valid_i = 1'b1; mc_addr_i = 6'd5; mc_data_i = 32'hAAAA;
        @(negedge clk);
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL bypass_ready0: got %b expected 1", mc_ready_o); end
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL bypass_latency: got we_a %b expected 0", we_a_o); end
        tick();
        mc_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd5, 32'hAAAA}) begin num_fails++; $display("[TB] FAIL bypass_port_a: got we=%b addr=%0d data=%h expected we=1 addr=5 data=0000aaaa", we_a_o, waddr_a_o, wdata_a_o); end
        num_checks++; if (we_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL bypass_we_b: got %b expected 0", we_b_o); end
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL bypass_ready1: got %b expected 1", mc_ready_o); end
        tick();
        @(negedge clk);
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL bypass_popped: got we_a %b expected 0", we_a_o); end
        tick();
    endtask

    task automatic test_port_b_drain();
        set_idle();
        alu_valid_i = 1'b1; alu_addr_i = 6'd1; alu_data_i = 32'h1001;
        mc_valid_i  = 1'b1; mc_addr_i  = 6'd7; mc_data_i  = 32'h70;
        @(negedge clk);
        num_checks++; if (we_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL drain_b_idle: got %b expected 0", we_b_o); end
        num_checks++; if ({we_a_o, waddr_a_o} !== {1'b1, 6'd1}) begin num_fails++; $display("[TB] FAIL drain_b_alu1: got we=%b addr=%0d expected we=1 addr=1", we_a_o, waddr_a_o); end
        tick();
        alu_addr_i = 6'd2; alu_data_i = 32'h1002;
        mc_addr_i  = 6'd8; mc_data_i  = 32'h80;
        @(negedge clk);
        num_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd7, 32'h70}) begin num_fails++; $display("[TB] FAIL drain_b_first: got we=%b addr=%0d data=%h expected we=1 addr=7 data=00000070", we_b_o, waddr_b_o, wdata_b_o); end
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL drain_b_ready: got %b expected 1", mc_ready_o); end
        tick();
        alu_addr_i = 6'd3; alu_data_i = 32'h1003;
        mc_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd8, 32'h80}) begin num_fails++; $display("[TB] FAIL drain_b_second: got we=%b addr=%0d data=%h expected we=1 addr=8 data=00000080", we_b_o, waddr_b_o, wdata_b_o); end
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd3, 32'h1003}) begin num_fails++; $display("[TB] FAIL drain_b_alu3: got we=%b addr=%0d data=%h expected we=1 addr=3 data=00001003", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
        alu_addr_i = 6'd4; alu_data_i = 32'h1004;
        @(negedge clk);
        num_checks++; if (we_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL drain_b_empty: got %b expected 0", we_b_o); end
        tick();
        set_idle();
    endtask

    task automatic test_full_backpressure();
        set_idle();
        alu_valid_i = 1'b1; alu_addr_i = 6'd2; alu_data_i = 32'h22;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd3; lsu_data_i = 32'h33;
        for (int k = 0; k < 3; k++) begin
            mc_valid_i = 1'b1;
            mc_addr_i  = 6'(9 + k);
            mc_data_i  = 32'h109 + 32'(k);
            @(negedge clk);
            num_checks++; if (mc_ready_o !== (k < 2)) begin num_fails++; $display("[TB] FAIL full_ready_%0d: got %b expected %b", k, mc_ready_o, (k < 2)); end
            tick();
        end
        mc_valid_i  = 1'b0;
        alu_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd9, 32'h109}) begin num_fails++; $display("[TB] FAIL full_pop_a: got we=%b addr=%0d data=%h expected we=1 addr=9 data=00000109", we_a_o, waddr_a_o, wdata_a_o); end
        num_checks++; if ({we_b_o, waddr_b_o} !== {1'b1, 6'd3}) begin num_fails++; $display("[TB] FAIL full_lsu_b: got we=%b addr=%0d expected we=1 addr=3", we_b_o, waddr_b_o); end
        num_checks++; if (mc_ready_o !== 1'b0) begin num_fails++; $display("[TB] FAIL full_ready_pop_cycle: got %b expected 0", mc_ready_o); end
        tick();
        lsu_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL full_ready_return: got %b expected 1", mc_ready_o); end
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd10, 32'h10a}) begin num_fails++; $display("[TB] FAIL full_pop_second: got we=%b addr=%0d data=%h expected we=1 addr=10 data=0000010a", we_a_o, waddr_a_o, wdata_a_o); end
        num_checks++; if (we_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL full_single_drain: got we_b %b expected 0", we_b_o); end
        tick();
        @(negedge clk);
        num_checks++; if ({we_a_o, we_b_o} !== 2'b00) begin num_fails++; $display("[TB] FAIL full_third_dropped: got we_a/we_b %b expected 00", {we_a_o, we_b_o}); end
        tick();
    endtask

    task automatic test_collision();
        set_idle();
        mc_valid_i = 1'b1; mc_addr_i = 6'd12; mc_data_i = 32'h12;
        tick();
        mc_valid_i  = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 6'd10; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd10; lsu_data_i = 32'h2;
        @(negedge clk);
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL coll_we_a: got %b expected 0", we_a_o); end
        num_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd10, 32'h2}) begin num_fails++; $display("[TB] FAIL coll_port_b: got we=%b addr=%0d data=%h expected we=1 addr=10 data=00000002", we_b_o, waddr_b_o, wdata_b_o); end
        num_checks++; if (collision_o !== 1'b1) begin num_fails++; $display("[TB] FAIL coll_flag: got %b expected 1", collision_o); end
        tick();
        set_idle();
        @(negedge clk);
        num_checks++; if (collision_o !== 1'b0) begin num_fails++; $display("[TB] FAIL coll_one_cycle: got %b expected 0", collision_o); end
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd12, 32'h12}) begin num_fails++; $display("[TB] FAIL coll_held_entry: got we=%b addr=%0d data=%h expected we=1 addr=12 data=00000012", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
        alu_valid_i = 1'b1; alu_addr_i = 6'd10; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd11; lsu_data_i = 32'h2;
        @(negedge clk);
        num_checks++; if ({collision_o, we_a_o, we_b_o} !== 3'b011) begin num_fails++; $display("[TB] FAIL coll_distinct: got coll/we_a/we_b %b expected 011", {collision_o, we_a_o, we_b_o}); end
        tick();
        set_idle();
    endtask

    task automatic test_scoreboard();
        set_idle();
        raddr_b_i = 6'd33;
        iss_valid_i = 1'b1; iss_addr_i = 6'd33;
        @(negedge clk);
        num_checks++; if (haz_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL sb_issue_cycle: got %b expected 0", haz_b_o); end
        tick();
        iss_valid_i = 1'b0;
        mc_valid_i = 1'b1; mc_addr_i = 6'd33; mc_data_i = 32'h333;
        @(negedge clk);
        num_checks++; if (haz_b_o !== 1'b1) begin num_fails++; $display("[TB] FAIL sb_set: got %b expected 1", haz_b_o); end
        tick();
        mc_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_a_o, waddr_a_o} !== {1'b1, 6'd33}) begin num_fails++; $display("[TB] FAIL sb_drain_write: got we=%b addr=%0d expected we=1 addr=33", we_a_o, waddr_a_o); end
        num_checks++; if (haz_b_o !== 1'b1) begin num_fails++; $display("[TB] FAIL sb_drain_cycle: got %b expected 1", haz_b_o); end
        tick();
        iss_valid_i = 1'b1; iss_addr_i = 6'd33;
        @(negedge clk);
        num_checks++; if (haz_b_o !== 1'b0) begin num_fails++; $display("[TB] FAIL sb_cleared: got %b expected 0", haz_b_o); end
        tick();
        iss_valid_i = 1'b0;
        mc_valid_i = 1'b1; mc_addr_i = 6'd33; mc_data_i = 32'h334;
        tick();
        mc_valid_i = 1'b0;
        iss_valid_i = 1'b1; iss_addr_i = 6'd33;
        @(negedge clk);
        num_checks++; if (we_a_o !== 1'b1) begin num_fails++; $display("[TB] FAIL sb_same_cycle_drain: got we_a %b expected 1", we_a_o); end
        tick();
        iss_valid_i = 1'b1; iss_addr_i = 6'd0;
        raddr_c_i = 6'd0;
        @(negedge clk);
        num_checks++; if (haz_b_o !== 1'b1) begin num_fails++; $display("[TB] FAIL sb_set_wins: got %b expected 1", haz_b_o); end
        tick();
        iss_valid_i = 1'b0;
        raddr_a_i = 6'd33;
        @(negedge clk);
        num_checks++; if (haz_c_o !== 1'b0) begin num_fails++; $display("[TB] FAIL sb_addr_zero: got %b expected 0", haz_c_o); end
        num_checks++; if (haz_a_o !== 1'b1) begin num_fails++; $display("[TB] FAIL sb_port_a_view: got %b expected 1", haz_a_o); end
        tick();
        set_idle();
    endtask

    task automatic test_zero_reset();
        set_idle();
        mc_valid_i = 1'b1; mc_addr_i = 6'd0; mc_data_i = 32'hDEAD;
        tick();
        mc_addr_i = 6'd6; mc_data_i = 32'h66;
        @(negedge clk);
        num_checks++; if (we_a_o !== 1'b0) begin num_fails++; $display("[TB] FAIL zero_we_a: got %b expected 0", we_a_o); end
        tick();
        mc_valid_i = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd6, 32'h66}) begin num_fails++; $display("[TB] FAIL zero_popped: got we=%b addr=%0d data=%h expected we=1 addr=6 data=00000066", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
        alu_valid_i = 1'b1; alu_addr_i = 6'd1; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd2; lsu_data_i = 32'h2;
        raddr_a_i = 6'd33; raddr_b_i = 6'd20;
        iss_valid_i = 1'b1; iss_addr_i = 6'd20;
        mc_valid_i = 1'b1; mc_addr_i = 6'd13; mc_data_i = 32'hD;
        @(negedge clk);
        num_checks++; if (haz_a_o !== 1'b1) begin num_fails++; $display("[TB] FAIL zero_pre_haz_a: got %b expected 1", haz_a_o); end
        tick();
        iss_valid_i = 1'b0;
        mc_addr_i = 6'd14; mc_data_i = 32'hE;
        @(negedge clk);
        num_checks++; if (haz_b_o !== 1'b1) begin num_fails++; $display("[TB] FAIL zero_pre_haz_b: got %b expected 1", haz_b_o); end
        tick();
        mc_valid_i = 1'b0; alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        num_checks++; if ({we_a_o, we_b_o} !== 2'b00) begin num_fails++; $display("[TB] FAIL mid_rst_we: got %b expected 00", {we_a_o, we_b_o}); end
        num_checks++; if ({haz_a_o, haz_b_o, mc_ready_o} !== 3'b000) begin num_fails++; $display("[TB] FAIL mid_rst_haz_ready: got %b expected 000", {haz_a_o, haz_b_o, mc_ready_o}); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        num_checks++; if ({we_a_o, we_b_o} !== 2'b00) begin num_fails++; $display("[TB] FAIL post_mid_rst_we: got %b expected 00", {we_a_o, we_b_o}); end
        num_checks++; if ({haz_a_o, haz_b_o, haz_c_o} !== 3'b000) begin num_fails++; $display("[TB] FAIL post_mid_rst_haz: got %b expected 000", {haz_a_o, haz_b_o, haz_c_o}); end
        num_checks++; if (mc_ready_o !== 1'b1) begin num_fails++; $display("[TB] FAIL post_mid_rst_ready: got %b expected 1", mc_ready_o); end
        tick();
        @(negedge clk);
        num_checks++; if ({we_a_o, we_b_o} !== 2'b00) begin num_fails++; $display("[TB] FAIL post_mid_rst_quiet: got %b expected 00", {we_a_o, we_b_o}); end
        tick();
    endtask

    // Scenario sequence
    initial begin
        num_checks = 0;
        num_fails  = 0;
        rst = 1'b1;
        set_idle();
        test_reset();
        test_fifo_bypass();
        test_port_b_drain();
        test_full_backpressure();
        test_collision();
        test_scoreboard();
        test_zero_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
